fir_result_collector: RTL and testbench
=======================================

Name: fir_result_collector

Overview:
- Consumer at the tail of the FIR MAC chain. Captures the final partial-sum stream (valid-only, no backpressure) and scales it by arithmetic right shift with rounding.
- Saturates each I/Q component to output width and buffers results in a small FIFO.
- Presents results on a valid/ready output with frame-end marking. Drives a stall back to the sample issuer so the non-stallable chain never overruns the FIFO.

Parameters:
- ACC_W, 32, width of each signed I/Q component of the incoming partial sum
- OUT_W, 16, width of each signed I/Q component of the output sample
- SHIFT_W, 5, width of the shift control
- DEPTH, 8, FIFO entries (power of 2, >=4)
- FLEN_W, 16, width of frame length and sample counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- acc_valid  in  1  partial-sum valid (from last MAC add_done)
- acc_data  in  2*ACC_W  partial sum {re, im}, two's complement
- mode  in  1  0 cross, 1 auto (auto: shift forced to 0)
- shift  in  SHIFT_W  right-shift amount, valid 0..ACC_W-1
- frame_len  in  FLEN_W  samples per frame; 0 = out_last never asserted
- clear  in  1  synchronous flush of pipeline, FIFO, counters and flags
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accept
- out_data  out  2*OUT_W  {re, im} scaled and saturated
- out_last  out  1  last sample of frame, qualified by out_valid
- stall  out  1  upstream must not issue new input_sample.valid
- overflow  out  1  sticky: a result was dropped at full FIFO
- sat_cnt  out  16  saturating count of saturated samples

Behaviour:
- Reset (rst=1) is highest priority and clears all state. clear is next in priority and has the same effect. Reset values: out_valid 0, out_data 0, out_last 0, stall 0, overflow 0, sat_cnt 0, FIFO empty, in-flight 0, sample counter 0.
- Stage 1 (registered on acc_valid):
  - Effective shift s = mode ? 0 : shift. mode and shift are sampled per sample in this cycle.
  - Each component: if s>0, compute (x + 2^(s-1)) >>> s in ACC_W+1 bits. This is round half toward +inf, with no internal wrap. If s=0, pass x unchanged.
- Stage 2 (registered):
  - Each component clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat flag = either component clamped. sat_cnt increments once per flagged sample and holds at 0xFFFF.
  - Result and last tag are then written to the FIFO.
- Latency: acc_valid at cycle T writes the FIFO at T+2. With an empty FIFO and out_ready=1, out_valid is high at T+3. Sustained throughput is 1 sample/cycle.
- Output handshake:
  - Transfer when out_valid && out_ready.
  - out_data and out_last hold stable while out_valid && !out_ready.
  - out_valid drops only after the last entry transfers.
- FIFO:
  - A write and a read in the same cycle at full are both accepted; count is unchanged.
  - A write at full with no read is dropped and sets overflow=1 (sticky until rst/clear). The sample counter still advances.
  - Reading when empty is impossible; out_valid is 0.
- stall: combinational from registered state. High when fifo_count + in_flight >= DEPTH-2, where in_flight counts valid stages 1–2. This guarantees no overflow for an upstream that reacts within 2 cycles.
- Frame counting:
  - The sample counter increments on each stage-2 result.
  - last tag = (frame_len != 0) && (cnt == frame_len-1). On last tag the counter wraps to 0.
  - frame_len is latched into an internal register when cnt==0. A change mid-frame takes effect at the next frame.
- Pointers wrap modulo DEPTH. count has width log2(DEPTH)+1.
- rst or clear asserted mid-frame discards all in-flight and buffered samples. The first sample afterwards is frame sample 0.

Test Plan:
- Rounding: mode=0, shift=4, acc_data re=24, im=-24, out_ready=1. Required: out_valid 3 cycles later with re=2, im=-1; sat_cnt=0.
- Saturation: shift=4, re=0x00200000, im=0xFFC00000. Required: re=0x7FFF, im=0x8000, sat_cnt=1. Repeat 70000 samples: sat_cnt holds at 0xFFFF.
- Auto mode: mode=1, shift=7, re=5, im=-3. Required: re=5, im=-3 (shift ignored).
- Backpressure and overflow: DEPTH=8, out_ready=0, push 1 sample/cycle.
  - stall rises when count+in_flight reaches 6.
  - Samples 1–8 stored; sample 9 is dropped and overflow=1.
  - Then out_ready=1: samples 1–8 emerge in order with stable data under stalls.
- Frames: frame_len=3, 7 consecutive samples. Required: out_last on samples 3 and 6 only. frame_len changed to 2 during sample 2 of a frame: takes effect only after that frame's out_last.
- Reset/clear mid-operation: 5 samples buffered, assert rst for 1 cycle. Required: out_valid=0, stall=0, overflow=0, sat_cnt=0 next cycle. The next sample's out_last counts from frame position 0. Same check for clear.

Source files
------------

// File: rtl/fir_result_collector.sv
// Purpose: scale (rounded arithmetic right shift), saturate and buffer the FIR partial-sum stream, tagging frame ends.
// Latency: acc_valid at T writes the FIFO at T+2; out_valid at T+3 when the FIFO was empty.
// Backpressure: input cannot be stalled; stall asks the issuer to pause before FIFO + in-flight reach capacity.
module fir_result_collector #(
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 16,
    parameter int SHIFT_W = 5,
    parameter int DEPTH   = 8,
    parameter int FLEN_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 acc_valid,
    input  logic [2*ACC_W-1:0]   acc_data,
    input  logic                 mode,
    input  logic [SHIFT_W-1:0]   shift,
    input  logic [FLEN_W-1:0]    frame_len,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*OUT_W-1:0]   out_data,
    output logic                 out_last,
    output logic                 stall,
    output logic                 overflow,
    output logic [15:0]          sat_cnt
);

    localparam int AW = $clog2(DEPTH);

    localparam logic signed [ACC_W:0] RND_ONE  = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] MAXV     = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV     = ~MAXV;
    localparam logic [AW-1:0]         PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]           CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]           FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW+1:0]         STALL_TH = (AW+2)'(DEPTH-2);
    localparam logic [FLEN_W-1:0]     FLEN_ONE = {{(FLEN_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic               last;
        logic [2*OUT_W-1:0] dat;
    } entry_t;

    // (x + 2^(s-1)) >>> s evaluated one bit wider than the input so the rounding add never wraps
    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] x,
                                                          input logic [SHIFT_W-1:0] s);
        logic signed [ACC_W:0] xe;
        logic signed [ACC_W:0] rnd;
        xe  = {x[ACC_W-1], x};
        rnd = RND_ONE << s;
        rnd = rnd >> 1;
        return (xe + rnd) >>> s;
    endfunction

    function automatic logic [OUT_W-1:0] clamp(input logic signed [ACC_W:0] v);
        if (v > MAXV)
            return MAXV[OUT_W-1:0];
        else if (v < MINV)
            return MINV[OUT_W-1:0];
        else
            return v[OUT_W-1:0];
    endfunction

    logic signed [ACC_W-1:0] acc_re;
    logic signed [ACC_W-1:0] acc_im;
    logic [SHIFT_W-1:0]      eff_shift;
    logic                    s1_vld;
    logic signed [ACC_W:0]   s1_re;
    logic signed [ACC_W:0]   s1_im;
    logic                    s1_sat;
    logic                    s2_vld;
    logic                    s2_last;
    logic [2*OUT_W-1:0]      s2_dat;
    logic [FLEN_W-1:0]       smp_cnt;
    logic [FLEN_W-1:0]       flen_q;
    logic [FLEN_W-1:0]       flen_eff;
    logic                    last_tag;
    entry_t                  mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             fifo_cnt;
    logic                    fifo_full;
    logic                    rd_en;
    logic                    wr_en;
    logic                    drop;
    logic [AW+1:0]           occ;

    assign acc_re    = acc_data[2*ACC_W-1:ACC_W];
    assign acc_im    = acc_data[ACC_W-1:0];
    assign eff_shift = mode ? '0 : shift;

    assign s1_sat    = (s1_re > MAXV) || (s1_re < MINV) || (s1_im > MAXV) || (s1_im < MINV);
    // frame_len is taken live at a frame start and the latched copy is used for the rest of the frame
    assign flen_eff  = (smp_cnt == '0) ? frame_len : flen_q;
    assign last_tag  = (flen_eff != '0) && (smp_cnt == flen_eff - FLEN_ONE);

    assign fifo_full = (fifo_cnt == FULL_CNT);
    assign out_valid = (fifo_cnt != '0);
    assign rd_en     = out_valid && out_ready;
    assign wr_en     = s2_vld && (!fifo_full || rd_en);
    assign drop      = s2_vld && fifo_full && !rd_en;
    assign out_data  = out_valid ? mem[rd_ptr].dat : '0;
    assign out_last  = out_valid && mem[rd_ptr].last;

    assign occ       = {1'b0, fifo_cnt} + (AW+2)'(s1_vld) + (AW+2)'(s2_vld);
    assign stall     = (occ >= STALL_TH);

    // Stage 1: rounded shift of both components, mode/shift sampled with the sample
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            s1_vld <= 1'b0;
            s1_re  <= '0;
            s1_im  <= '0;
        end else begin
            s1_vld <= acc_valid;
            if (acc_valid) begin
                s1_re <= round_shift(acc_re, eff_shift);
                s1_im <= round_shift(acc_im, eff_shift);
            end
        end
    end

    // Stage 2: saturate, count saturations, tag frame ends and advance the sample counter
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            s2_dat  <= '0;
            smp_cnt <= '0;
            flen_q  <= '0;
            sat_cnt <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (smp_cnt == '0)
                flen_q <= frame_len;
            if (s1_vld) begin
                s2_dat  <= {clamp(s1_re), clamp(s1_im)};
                s2_last <= last_tag;
                smp_cnt <= last_tag ? '0 : smp_cnt + FLEN_ONE;
                if (s1_sat && sat_cnt != 16'hFFFF)
                    sat_cnt <= sat_cnt + 16'd1;
            end
        end
    end

    // FIFO storage: no reset needed, reads are masked by out_valid
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= '{last: s2_last, dat: s2_dat};
    end

    // FIFO pointers, occupancy and sticky overflow; a write at full is accepted only alongside a read
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_en, rd_en})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (drop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_result_collector.sv
// Purpose: scoreboard bench for fir_result_collector with directed, hand-computed vectors.
// Latency: checks the 3-cycle acc_valid to out_valid path and frame/overflow timing.
// Backpressure: drives out_ready low/toggling and checks output hold stability.
module tb_fir_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_valid;
    logic [63:0] acc_data;
    logic        mode;
    logic [4:0]  shift;
    logic [15:0] frame_len;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        stall;
    logic        overflow;
    logic [15:0] sat_cnt;

    typedef struct packed {
        logic        last;
        logic [31:0] dat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        hold_pend = 1'b0;
    logic [32:0] held = '0;

    fir_result_collector dut (
        .clk       (clk),
        .rst       (rst),
        .acc_valid (acc_valid),
        .acc_data  (acc_data),
        .mode      (mode),
        .shift     (shift),
        .frame_len (frame_len),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .stall     (stall),
        .overflow  (overflow),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every transfer, and check hold stability while stalled
    always @(negedge clk) begin
        exp_t e;
        if (hold_pend) begin
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_data", {31'd0, out_last, out_data}, {31'd0, held});
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", {out_last, out_data});
            end else begin
                e = sb.pop_front();
                check("out_sample", {31'd0, out_last, out_data}, {31'd0, e.last, e.dat});
            end
        end
        hold_pend = out_valid && !out_ready && !rst && !clear;
        held      = {out_last, out_data};
    end

    task automatic send(input logic [31:0] re, input logic [31:0] im,
                        input logic [15:0] ere, input logic [15:0] eim,
                        input logic el, input logic push);
        acc_valid = 1'b1;
        acc_data  = {re, im};
        if (push)
            sb.push_back('{last: el, dat: {ere, eim}});
        @(posedge clk);
        #1;
        acc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic pulse(input logic is_rst);
        if (is_rst) rst = 1'b1; else clear = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        clear = 1'b0;
        sb.delete();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; acc_valid = 1'b0; acc_data = '0;
        mode = 1'b0; shift = '0; frame_len = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        check("rst_out_last", {63'd0, out_last}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_sat_cnt", {48'd0, sat_cnt}, 64'd0);
        rst = 1'b0;
        idle(1);

        // Rounding: 24>>4 -> 2, -24>>4 -> -1, with exact 3-cycle latency
        out_ready = 1'b1;
        shift = 5'd4;
        send(32'd24, 32'hFFFF_FFE8, 16'h0002, 16'hFFFF, 1'b0, 1'b1);
        idle(1);
        check("lat_t2_not_valid", {63'd0, out_valid}, 64'd0);
        idle(1);
        check("lat_t3_valid", {63'd0, out_valid}, 64'd1);
        idle(3);
        check("round_sat_cnt", {48'd0, sat_cnt}, 64'd0);

        // Auto mode ignores shift
        mode = 1'b1; shift = 5'd7;
        send(32'd5, 32'hFFFF_FFFD, 16'h0005, 16'hFFFD, 1'b0, 1'b1);
        idle(4);
        mode = 1'b0;

        // Saturation of both components
        shift = 5'd4;
        send(32'h0020_0000, 32'hFFC0_0000, 16'h7FFF, 16'h8000, 1'b0, 1'b1);
        idle(4);
        check("sat_cnt_one", {48'd0, sat_cnt}, 64'd1);
        drain("basic");

        // Backpressure: 9 back-to-back samples, stall at occupancy 6, 9th dropped
        shift = 5'd0;
        out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            acc_valid = 1'b1;
            acc_data  = {32'(k * 100), 32'(-k)};
            if (k <= 8)
                sb.push_back('{last: 1'b0, dat: {16'(k * 100), 16'(-k)}});
            @(negedge clk);
            check($sformatf("stall_k%0d", k), {63'd0, stall}, {63'd0, (k >= 7)});
            if (k == 9)
                check("overflow_before_drop", {63'd0, overflow}, 64'd0);
            @(posedge clk);
            #1;
        end
        acc_valid = 1'b0;
        idle(4);
        check("overflow_set", {63'd0, overflow}, 64'd1);
        check("stall_full", {63'd0, stall}, 64'd1);
        for (int c = 0; c < 30; c++) begin
            out_ready = (c % 3 != 2);
            idle(1);
        end
        out_ready = 1'b1;
        drain("backpressure");
        check("overflow_sticky", {63'd0, overflow}, 64'd1);

        // Reset mid-frame with 5 samples buffered
        frame_len = 16'd2;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            send(32'(k), 32'(k), 16'd0, 16'd0, 1'b0, 1'b0);
        idle(4);
        pulse(1'b1);
        check("rstmid_out_valid", {63'd0, out_valid}, 64'd0);
        check("rstmid_stall", {63'd0, stall}, 64'd0);
        check("rstmid_overflow", {63'd0, overflow}, 64'd0);
        check("rstmid_sat_cnt", {48'd0, sat_cnt}, 64'd0);
        out_ready = 1'b1;
        send(32'd1, 32'd1, 16'd1, 16'd1, 1'b0, 1'b1);
        send(32'd2, 32'd2, 16'd2, 16'd2, 1'b1, 1'b1);
        drain("after_rst");

        // Clear mid-frame after overflow and a saturated sample
        out_ready = 1'b0;
        send(32'h0001_0000, 32'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            send(32'(k), 32'(k), 16'd0, 16'd0, 1'b0, 1'b0);
        idle(4);
        check("clr_pre_overflow", {63'd0, overflow}, 64'd1);
        check("clr_pre_sat_cnt", {48'd0, sat_cnt}, 64'd1);
        pulse(1'b0);
        check("clr_out_valid", {63'd0, out_valid}, 64'd0);
        check("clr_stall", {63'd0, stall}, 64'd0);
        check("clr_overflow", {63'd0, overflow}, 64'd0);
        check("clr_sat_cnt", {48'd0, sat_cnt}, 64'd0);
        out_ready = 1'b1;
        send(32'd3, 32'd3, 16'd3, 16'd3, 1'b0, 1'b1);
        send(32'd4, 32'd4, 16'd4, 16'd4, 1'b1, 1'b1);
        drain("after_clear");

        // Frames of 3: last on samples 3 and 6
        frame_len = 16'd3;
        for (int k = 1; k <= 7; k++)
            send(32'(k), 32'd0, 16'(k), 16'd0, (k == 3 || k == 6), 1'b1);
        idle(4);
        send(32'd8, 32'd0, 16'd8, 16'd0, 1'b0, 1'b1);
        idle(4);
        // Change mid-frame: this frame still ends at length 3
        frame_len = 16'd2;
        send(32'd9, 32'd0, 16'd9, 16'd0, 1'b1, 1'b1);
        idle(4);
        for (int k = 10; k <= 13; k++)
            send(32'(k), 32'd0, 16'(k), 16'd0, (k == 11 || k == 13), 1'b1);
        drain("frames");

        // Long saturating run: sat_cnt must stick at 0xFFFF
        frame_len = 16'd0;
        pulse(1'b0);
        shift = 5'd4;
        for (int k = 0; k < 70000; k++)
            send(32'h0020_0000, 32'hFFC0_0000, 16'h7FFF, 16'h8000, 1'b0, 1'b1);
        drain("sat_long");
        check("sat_cnt_hold", {48'd0, sat_cnt}, 64'h0000_0000_0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
